// File: rtl/serial_subtractor_nand_if.sv
// Handshake and operand/result bundle for serial_subtractor_nand.
// SERIAL_SUBTRACTOR_OVF_EN adds the registered signed-overflow flag ovf.
interface serial_subtractor_nand_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

  modport master (
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    input  ovf,
`endif
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output ovf,
`endif
    input  start, a, b,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor_nand.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, built from NAND-only cells.
// Optional macro SERIAL_SUBTRACTOR_OVF_EN adds the registered signed-overflow output ovf.

// NAND-only half subtractor: d = x ^ y, bo = ~x & y.
module serial_subtractor_nand_hs (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  logic n_xy;
  logic n_x_nxy;
  logic n_y_nxy;
  logic n_x;
  logic n_nx_y;

  assign n_xy    = ~(x & y);
  assign n_x_nxy = ~(x & n_xy);
  assign n_y_nxy = ~(y & n_xy);
  assign d       = ~(n_x_nxy & n_y_nxy);

  assign n_x     = ~(x & x);
  assign n_nx_y  = ~(n_x & y);
  assign bo      = ~(n_nx_y & n_nx_y);
endmodule

// Full subtractor from two half subtractors; borrows merged by a NAND-built OR.
module serial_subtractor_nand_fs (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);
  logic d1;
  logic b1;
  logic b2;
  logic n_b1;
  logic n_b2;

  serial_subtractor_nand_hs u_hs0 (.x(x),  .y(y),   .d(d1), .bo(b1));
  serial_subtractor_nand_hs u_hs1 (.x(d1), .y(bin), .d(d),  .bo(b2));

  assign n_b1 = ~(b1 & b1);
  assign n_b2 = ~(b2 & b2);
  assign bo   = ~(n_b1 & n_b2);
endmodule

module serial_subtractor_nand #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor_nand_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             capture;
  logic             last_bit;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             done_q;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] res_nxt;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             a_msb;
  logic             b_msb;
  logic             ovf_q;
`endif

  serial_subtractor_nand_fs u_cell (
    .x  (op_a[0]),
    .y  (op_b[0]),
    .bin(borrow),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign res_nxt = {cell_d, res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last_bit  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The final bit's difference is merged straight into diff so the result lands
  // on the same edge as the last shift, without an extra drain cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (capture) begin
        op_a   <= bus.a;
        op_b   <= bus.b;
        res    <= '0;
        borrow <= 1'b0;
        cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        a_msb  <= bus.a[WIDTH-1];
        b_msb  <= bus.b[WIDTH-1];
`endif
      end else if (state == SHIFT) begin
        op_a   <= op_a >> 1;
        op_b   <= op_b >> 1;
        res    <= res_nxt;
        borrow <= cell_bo;
        cnt    <= cnt + 1'b1;
        if (last_bit) begin
          diff_q <= res_nxt;
          bout_q <= cell_bo;
          done_q <= 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_q  <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
`endif
        end
      end
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor_nand.sv
// Randomized self-checking bench for serial_subtractor_nand (WIDTH=8) against an arithmetic model.
// With SERIAL_SUBTRACTOR_OVF_EN defined, the ovf output is checked as well.
module tb_serial_subtractor_nand;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] exp_diff;
  logic       exp_bout;
  logic       exp_ovf;

  serial_subtractor_nand_if #(.WIDTH(8)) bus ();

  serial_subtractor_nand #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_diff"}, 32'(bus.diff), 32'(exp_diff));
    check({tag, "_bout"}, 32'(bus.bout), 32'(exp_bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`endif
  endtask

  // Model: unsigned modular difference, borrow as a<b, overflow from the signed range.
  task automatic model(input logic [7:0] x, input logic [7:0] y);
    int r;
    exp_diff = x - y;
    exp_bout = (x < y);
    r = int'($signed(x)) - int'($signed(y));
    exp_ovf = (r > 127) || (r < -128);
  endtask

  // Starts an operation at the current negedge and follows it to completion.
  // From cycle noise_at onward start is held high with noise operands (must be ignored).
  task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                       input int noise_at, input logic [7:0] na, input logic [7:0] nb);
    int lat;
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      check("busy_run", 32'(bus.busy), 32'd1);
      check_outputs("hold");
      if (lat == noise_at) begin
        bus.start = 1'b1;
        bus.a     = na;
        bus.b     = nb;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    model(x, y);
    check("latency", 32'(lat), 32'd8);
    check("busy_done", 32'(bus.busy), 32'd0);
    check_outputs("result");
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_done", 32'(bus.done), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check_outputs("idle");
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_diff  = '0;
    exp_bout  = 1'b0;
    exp_ovf   = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check_outputs("rst");
    rst_n = 1'b1;
    idle(2);

    do_op(8'h5A, 8'h3C, -1, 8'h00, 8'h00);
    idle(1);

    do_op(8'h10, 8'h20, -1, 8'h00, 8'h00);
    do_op(8'hFF, 8'h01, -1, 8'h00, 8'h00);
    idle(1);

    do_op(8'h07, 8'h03, 3, 8'h00, 8'hFF);
    idle(2);

    // Reset during an operation aborts it with no done pulse.
    bus.start = 1'b1;
    bus.a     = 8'h80;
    bus.b     = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    exp_diff = '0;
    exp_bout = 1'b0;
    exp_ovf  = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check_outputs("abort");
    idle(10);

    do_op(8'h80, 8'h01, -1, 8'h00, 8'h00);
    do_op(8'h05, 8'h03, -1, 8'h00, 8'h00);
    do_op(8'h33, 8'h33, -1, 8'h00, 8'h00);
    do_op(8'h00, 8'hFF, -1, 8'h00, 8'h00);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] x;
      logic [7:0] y;
      int nat;
      x   = 8'($urandom);
      y   = 8'($urandom);
      nat = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
      do_op(x, y, nat, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor_nand.md
Name: serial_subtractor_nand

Overview:
- Bit-serial N-bit subtractor computing diff = a − b.
- Operands are loaded in parallel, then processed LSB-first, one bit per clock.
- Each bit is processed by a full-subtractor cell built from two NAND-only half-subtractor stages plus a NAND-implemented OR for borrow merge. A borrow flip-flop carries between bits.
- Sits downstream of the NAND half-subtractor cell: consumes its Diff/Bout per bit and produces a registered multi-bit result with a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when diff/bout are updated
- diff  output  WIDTH  registered difference (a − b) mod 2^WIDTH
- bout  output  1  registered final borrow (1 when a < b, unsigned)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-low (rst_n).
- Reset (rst_n=0 at a clk edge): state=IDLE, busy=0, done=0, diff=0, bout=0. Internal shift registers, borrow flop and bit counter are cleared.
- FSM states: IDLE, SHIFT.
- IDLE:
  - If start=1, latch a/b into operand shift registers, clear borrow flop, set counter=0, go to SHIFT; busy=1 from the next cycle.
  - If start=0, hold.
- SHIFT, each edge:
  - Bit cell inputs: x = opA[0], y = opB[0], bin = borrow flop.
  - Cell outputs: d = x^y^bin; bo = (~x&y) | (~(x^y)&bin).
  - Shift d into the MSB of the result shift register. Shift opA/opB right by one. Set borrow ← bo. Increment counter.
  - On the edge where counter reaches WIDTH−1 (the final bit): load diff ← completed result, bout ← bo, done=1, busy=0, go to IDLE.
- Latency: start sampled at edge 0 → done=1 and new diff/bout visible after edge WIDTH (WIDTH cycles). Throughput: one operation per WIDTH cycles.
- done: high exactly one cycle; low otherwise.
- diff/bout: hold the last result until the next done. They are not disturbed during SHIFT.
- start while busy=1: ignored, with no effect on the operation in flight.
- Back-to-back: start=1 in the same cycle done=1 (state already IDLE) is accepted.
- a/b changing during SHIFT: no effect (operands already captured).
- Reset mid-operation: aborts immediately. All outputs go to their reset values; no done pulse.
- Arithmetic: unsigned modulo 2^WIDTH. Equal operands give diff=0, bout=0.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN
- Defined:
  - Adds output port ovf (1 bit, registered).
  - Updated with done: ovf = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), computed from the captured operands (signed two's-complement overflow).
  - Reset value 0; holds between operations.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- Reset then idle: rst_n=0 for 2 cycles, start=0 → busy=0, done=0, diff=0x00, bout=0.
- Basic subtraction: a=0x5A, b=0x3C, start pulse → busy for 8 cycles, done pulse 8 cycles after start, diff=0x1E, bout=0.
- Borrow case: a=0x10, b=0x20 → diff=0xF0, bout=1. Then a=0xFF, b=0x01 accepted on the done cycle → diff=0xFE, bout=0 exactly 8 cycles later.
- Start ignored while busy: a=0x07, b=0x03 start; at cycle 3 drive start=1 with a=0x00, b=0xFF → single done, diff=0x04, bout=0.
- Reset mid-operation: start a=0x80, b=0x01; assert rst_n=0 at cycle 4 → next edge busy=0, diff=0, bout=0, no done; a new start then completes normally.
- With SERIAL_SUBTRACTOR_OVF_EN: a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1. Then a=0x05, b=0x03 → diff=0x02, ovf=0.
